div_seq: RTL and testbench

//  Iterative radix-2 restoring divider with its sequencing FSM for DIV/DIVU in the EX stage.

---
 rtl/div_seq.sv | 117 +++++++++++
 tb/tb_div_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// It produces {remainder, quotient} after 32 iteration cycles and requests a
// pipeline stall while the operation is outstanding.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ZERO = 2'd1,
    S_ON       = 2'd2,
    S_END      = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;        // partial remainder, one guard bit for compare/subtract
  logic [WIDTH-1:0] dvd;        // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dsr;        // latched divisor magnitude
  logic             neg_q;      // quotient must be negated at the end
  logic             neg_r;      // remainder must be negated at the end

  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH:0]   rem_next;
  logic             qbit;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Stall the pipeline from the issue cycle until the result is presented.
  assign stall_req = start & ~annul & (state != S_END);

  // Operand magnitudes and one restoring-division step with final sign fixup.
  always_comb begin
    abs1      = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + WIDTH'(1)) : opdata1;
    abs2      = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + WIDTH'(1)) : opdata2;
    rem_shift = (rem << 1) | (WIDTH+1)'(dvd[WIDTH-1]);
    rem_diff  = rem_shift - {1'b0, dsr};
    qbit      = (rem_shift >= {1'b0, dsr});
    rem_next  = qbit ? rem_diff : rem_shift;
    quot_next = {dvd[WIDTH-2:0], qbit};
    quot_fix  = neg_q ? (~quot_next + WIDTH'(1)) : quot_next;
    rem_fix   = neg_r ? (~rem_next[WIDTH-1:0] + WIDTH'(1)) : rem_next[WIDTH-1:0];
  end

  // Sequencing FSM with datapath registers and registered result/ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      result <= '0;
      ready  <= 1'b0;
      rem    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (annul) begin
      state <= S_IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            neg_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_r <= signed_div & opdata1[WIDTH-1];
            dvd   <= abs1;
            dsr   <= abs2;
            rem   <= '0;
            count <= '0;
            state <= (opdata2 == '0) ? S_DIV_ZERO : S_ON;
          end
        end
        S_DIV_ZERO: begin
          result <= '0;
          ready  <= 1'b1;
          state  <= S_END;
        end
        S_ON: begin
          rem   <= rem_next;
          dvd   <= quot_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            result <= {rem_fix, quot_fix};
            ready  <= 1'b1;
            state  <= S_END;
          end
        end
        S_END: begin
          if (!start) begin
            ready <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq with directed and random divides.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  typedef struct {
    logic [63:0] res;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic ready_q  = 1'b0;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; signed uses 64-bit truncating division.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sd);
    longint sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sd) return {a % b, a / b};
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    q   = sa / sbv;
    r   = sa % sbv;
    return {32'(r), 32'(q)};
  endfunction

  // Monitor: on each rising ready, pop expected entry and compare value and latency.
  always @(negedge clk) begin
    exp_t e;
    if (ready && !ready_q) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", 64'(cyc - e.issue + 1), 64'(e.lat));
      end
    end
    ready_q = ready;
  end

  // Issue one divide, hold start through END briefly, then release it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sd);
    exp_t e;
    int   n;
    opdata1    = a;
    opdata2    = b;
    signed_div = sd;
    start      = 1'b1;
    e.res      = model(a, b, sd);
    e.issue    = cyc + 1;
    e.lat      = (b == 32'd0) ? 2 : 33;
    sb.push_back(e);
    #1 check("stall_issue", 64'(stall_req), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ready) begin
        if (n == 1 || n == 16) check("stall_busy", 64'(stall_req), 64'd1);
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom);
      end
    end while (!ready && n < 60);
    if (!ready) begin
      check("timeout", 64'(ready), 64'd1);
      start = 1'b0;
      void'(sb.pop_front());
      @(negedge clk);
      return;
    end
    check("stall_end", 64'(stall_req), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, e.res);
    end
    start = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'(ready), 64'd0);
    check("result_kept", result, e.res);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0);
    check("divu_100_7", result, {32'd2, 32'd14});
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("div_min_neg1", result, {32'd0, 32'h8000_0000});
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(32'h1234_5678, 32'd0, 1'b1);
    do_op(32'hFFFF_FFFF, 32'd0, 1'b0);

    // Annul mid-operation, then issue a fresh divide right after.
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1 check("annul_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    check("annul_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    do_op(32'd9, 32'd3, 1'b0);
    check("after_annul", result, {32'd0, 32'd3});

    // Asynchronous reset mid-operation.
    opdata1    = 32'd77;
    opdata2    = 32'd5;
    signed_div = 1'b0;
    start      = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_result", result, 64'd0);
    check("async_rst_ready", 64'(ready), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd50, 32'd5, 1'b0);
    check("after_rst", result, {32'd0, 32'd10});

    // Random divides, including small and zero divisors.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      do_op(a, b, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
